// File: rtl/fifo_sync_ctl.sv
// fifo_sync_ctl
// Single-clock FIFO for the acquisition data path, sitting between the sample
// producers and the packetiser/readout logic. Supports any depth >= 2,
// standard registered read or first-word-fall-through, programmable
// almost-full/almost-empty thresholds, a synchronous flush, write-through when
// full (a write is accepted on a full FIFO if a read is accepted in the same
// cycle) and sticky overflow/underflow flags.
//
// Ports
//   clk_i           clock, all logic on the rising edge
//   rst_n_i         synchronous active-low reset
//   flush_i         synchronous clear of contents (data and error flags kept)
//   clr_err_i       clears the sticky error flags
//   wr_en_i         write request
//   wr_data_i       write data
//   rd_en_i         read request (FWFT: pop of the head word)
//   rd_data_o       read data
//   rd_valid_o      rd_data_o holds a valid word
//   full_o          count == DEPTH
//   empty_o         count == 0
//   almost_full_o   count >= AFULL_THRESH
//   almost_empty_o  count <= AEMPTY_THRESH
//   count_o         number of words stored
//   overflow_o      sticky: a write was rejected
//   underflow_o     sticky: a read was rejected
module fifo_sync_ctl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned ADDR_WIDTH    = $clog2(DEPTH),
    parameter bit          FWFT          = 1'b0,
    parameter int unsigned AFULL_THRESH  = DEPTH - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  clr_err_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic empty, full;
    logic rd_acc, wr_acc;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    assign rd_acc = rd_en_i & ~empty;
    assign wr_acc = wr_en_i & (~full | rd_acc);

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush_i) begin
            // Requests are ignored during flush and error flags are left alone.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // A new error event wins over a clear in the same cycle.
            if (clr_err_i) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            if (wr_en_i && !wr_acc) overflow_d  = 1'b1;
            if (rd_en_i && empty)   underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; only words between the pointers are ever observed.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && !flush_i && wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented directly; forced to zero when empty so the
            // output is deterministic after reset.
            assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
            assign rd_valid_o = ~empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
            logic                  rd_valid_q, rd_valid_d;

            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = 1'b0;
                if (!flush_i && rd_acc) begin
                    rd_data_d  = mem_q[rd_ptr_q];
                    rd_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data_o  = rd_data_q;
            assign rd_valid_o = rd_valid_q;
        end
    endgenerate

    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= AFULL_C);
    assign almost_empty_o = (count_q <= AEMPTY_C);
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: doc/fifo_sync_ctl.md
# fifo_sync_ctl

Parametrised single-clock FIFO, the successor to the plain synchronous FIFO on the acquisition data path. It adds first-word-fall-through (FWFT) mode, non-power-of-two depth, programmable almost-full/almost-empty thresholds, a synchronous flush, write-through-when-full and sticky overflow/underflow error flags. It sits between sample producers (ADC/front-end) and the packetiser/readout logic.

## Interface
- DATA_WIDTH, 32, word width in bits
- DEPTH, 1024, capacity in words; any value ≥ 2, power of two not required
- ADDR_WIDTH, $clog2(DEPTH), pointer width (derived)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AFULL_THRESH, DEPTH-4, almost_full asserts when count ≥ this; range 1..DEPTH
- AEMPTY_THRESH, 4, almost_empty asserts when count ≤ this; range 0..DEPTH-1
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous clear of contents
- clr_err  in  1  clears sticky error flags
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request (FWFT: pop/acknowledge)
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data holds a valid word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_THRESH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- count  out  ADDR_WIDTH+1  words stored
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

## Operation
- One clock; reset is synchronous and active-low. Reset values: rd_data 0, rd_valid 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, both pointers 0.
- Priority: rst_n low > flush > normal operation.
- rd_acc = rd_en & !empty. wr_acc = wr_en & (!full | rd_acc); a write is accepted on a full FIFO when a read is accepted in the same cycle.
- Pointers wrap DEPTH-1 → 0 explicitly (no reliance on binary rollover). count +1 on write only, −1 on read only, unchanged on both or neither.
- Status flags are pure functions of registered count.
- FWFT=0: on rd_acc, rd_data ← mem[rd_ptr] at that edge, rd_valid = 1 for exactly the following cycle. Otherwise rd_data holds and rd_valid = 0.
- FWFT=1: rd_data continuously presents the head word, rd_valid = !empty, rd_en pops the head. When empty, rd_data is don't-care.
- overflow set when wr_en & !wr_acc. underflow set when rd_en & empty. Both stay set until rst_n or clr_err. Set wins over clr_err in the same cycle.
- flush: pointers and count go to 0 and rd_valid to 0 at the edge. wr_en and rd_en are ignored that cycle (no error flags set). rd_data and error flags are retained.

## Timing
- Write at edge N: count, empty and the almost flags update after edge N.
- FWFT=0: rd_en sampled at edge M gives data and rd_valid after edge M (1-cycle latency). Minimum write-to-data is 2 edges.
- FWFT=1: a word written into an empty FIFO at edge N is on rd_data with rd_valid=1 after edge N. A pop at edge M exposes the next word after edge M.
- Sustained throughput is 1 word/clk in and out simultaneously at any fill level, including full and (FWFT=1) single-entry.
- Empty + wr_en + rd_en: write accepted, read rejected, underflow set, count → 1.
- Reset asserted mid-burst: all state is cleared at that edge and in-flight requests are dropped.

## Test plan
- DEPTH=5, FWFT=0: write 0xA0..0xA4, 6th write → full=1, overflow=1, count=5. Read 5 → 0xA0..0xA4 in order, each 1 cycle after rd_en. Extra read → underflow=1.
- DEPTH=5 wrap: 3 writes/3 reads, repeated ×4 → data order intact, pointers wrap at 4, count never exceeds 3.
- Full + simultaneous wr_en/rd_en for 10 cycles → count stays 5, overflow stays 0, outputs are the first 10 words in order.
- FWFT=1: write 0x55 into empty → after same edge rd_valid=1 and rd_data=0x55 with no rd_en. Pop → rd_valid=0, empty=1.
- Thresholds AFULL=4, AEMPTY=1: fill 0→5 → almost_empty drops at count 2, almost_full rises at count 4. flush at count 5 → count=0, empty=1, rd_valid=0, overflow retained until clr_err.
- Pull rst_n low mid-stream with wr_en=1 → next cycle count=0, rd_data=0, flags at reset values, no write stored.
